// File: rtl/adc_axis_ingest.sv
// adc_axis_ingest: converts offset-binary ADC samples to signed, scaled 64-bit
// samples, buffers them in a first-word-fall-through FIFO and presents them as
// an AXI-Stream master with tlast framing every FRAME_LEN samples.
module adc_axis_ingest #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int ADC_WIDTH              = 8,
  parameter int FIFO_DEPTH             = 8,
  parameter int FRAME_LEN              = 1024
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic [ADC_WIDTH-1:0]                  adc_data,
  input  logic                                  adc_valid,
  input  logic                                  enable,
  input  logic [3:0]                            shift,
  input  logic                                  clear_overflow,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic                                  overflow,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level
);

  localparam int W      = C_M00_AXIS_TDATA_WIDTH;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam int FCNT_W = $clog2(FRAME_LEN);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  // Remove the midscale offset, sign-extend to the stream width, then scale.
  // The centred value fits in ADC_WIDTH+1 bits and a shift of at most 15
  // stays far below the stream width, so no saturation is required.
  function automatic logic signed [W-1:0] adc_to_sample(
    input logic [ADC_WIDTH-1:0] raw,
    input logic [3:0]           sh
  );
    logic signed [ADC_WIDTH:0] centred;
    logic signed [W-1:0]       wide;
    centred = $signed({1'b0, raw}) - $signed({2'b01, {(ADC_WIDTH-1){1'b0}}});
    wide    = {{(W-ADC_WIDTH-1){centred[ADC_WIDTH]}}, centred};
    return wide <<< sh;
  endfunction

  // ---------------- stage 1: conversion register ----------------
  logic                vld_p1_q, vld_p1_d;
  logic signed [W-1:0] data_p1_q, data_p1_d;

  // Capture a converted sample whenever the ADC presents one while enabled.
  always_comb begin
    vld_p1_d  = adc_valid && enable;
    data_p1_d = data_p1_q;
    if (adc_valid && enable) begin
      data_p1_d = adc_to_sample(adc_data, shift);
    end
  end

  // Stage-1 valid bit; cleared by reset so in-flight samples are discarded.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  // Stage-1 data register carries no reset; it is qualified by vld_p1_q.
  always_ff @(posedge s00_axis_aclk) begin
    data_p1_q <= data_p1_d;
  end

  // ---------------- stage 2: FIFO push / AXIS pop ----------------
  logic [W:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic              fifo_nonempty, fifo_full;
  logic              pop, push_ok, drop, last_flag;
  logic [W:0]        head;

  // FIFO bookkeeping: a pop frees a slot in the same cycle, so a push into a
  // full FIFO is only dropped when the head is not leaving.
  always_comb begin
    fifo_nonempty = (level_q != '0);
    fifo_full     = (level_q == LVL_FULL);
    pop           = fifo_nonempty && m00_axis_tready;
    push_ok       = vld_p1_q && (!fifo_full || pop);
    drop          = vld_p1_q && fifo_full && !pop;
    last_flag     = (frame_cnt_q == FCNT_LAST);

    wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Frame count only advances on samples that actually enter the FIFO and
    // is held at zero while disabled so frames restart aligned.
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      frame_cnt_d = '0;
    end else if (push_ok) begin
      frame_cnt_d = last_flag ? '0 : frame_cnt_q + FCNT_W'(1);
    end

    // A new drop wins over a simultaneous clear request.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // FIFO control state with asynchronous reset.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage: {tlast, sample} written at the write pointer.
  always_ff @(posedge s00_axis_aclk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {last_flag, data_p1_q};
    end
  end

  // Outputs come from registered state only; empty FIFO presents zeros.
  assign head            = mem_q[rd_ptr_q];
  assign m00_axis_tvalid = fifo_nonempty;
  assign m00_axis_tdata  = fifo_nonempty ? head[W-1:0] : '0;
  assign m00_axis_tlast  = fifo_nonempty && head[W];
  assign m00_axis_tstrb  = {(W/8){fifo_nonempty}};
  assign overflow        = overflow_q;
  assign fifo_level      = level_q;

endmodule

// File: tb/tb_adc_axis_ingest.sv
// Testbench for adc_axis_ingest: directed scenarios plus a randomized phase,
// checked each cycle against a queue-based transaction model.
module tb_adc_axis_ingest;

  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_LEN  = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        enable;
  logic [3:0]  shift;
  logic        clear_overflow;
  logic        m_tready;
  logic        m_tvalid;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;
  logic        m_tlast;
  logic        overflow;
  logic [3:0]  fifo_level;

  adc_axis_ingest #(
    .C_M00_AXIS_TDATA_WIDTH(64),
    .ADC_WIDTH(8),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_aresetn(aresetn),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .enable(enable),
    .shift(shift),
    .clear_overflow(clear_overflow),
    .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb),
    .m00_axis_tlast(m_tlast),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  int          m_fcnt;
  logic        m_ovf;
  logic        pend_v;
  logic [63:0] pend_d;

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  logic log_en  = 1'b0;
  int   log_n   = 0;
  logic last_log [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fcnt = 0;
    m_ovf  = 1'b0;
    pend_v = 1'b0;
    pend_d = '0;
  endtask

  task automatic compare_model();
    chk("tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
    chk("level", 64'(fifo_level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("tstrb", 64'(m_tstrb), (mq.size() != 0) ? 64'hFF : 64'h0);
    if (mq.size() != 0) begin
      chk("tdata", m_tdata, mq[0].data);
      chk("tlast", 64'(m_tlast), 64'(mq[0].last));
    end
  endtask

  // One clock: log handshake, advance model with pre-edge inputs, compare.
  task automatic tick();
    logic pop;
    if (log_en && m_tvalid && m_tready && log_n < 32) begin
      last_log[log_n] = m_tlast;
      log_n++;
    end
    @(posedge clk);
    pop = (mq.size() != 0) && m_tready;
    if (pop) void'(mq.pop_front());
    if (pend_v) begin
      if (mq.size() < FIFO_DEPTH) begin
        mq.push_back({(m_fcnt == FRAME_LEN - 1), pend_d});
        m_fcnt = (m_fcnt + 1) % FRAME_LEN;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (clear_overflow) begin
      m_ovf = 1'b0;
    end
    if (pend_v && mq.size() == FIFO_DEPTH && !pop && clear_overflow) m_ovf = 1'b1;
    if (!enable) m_fcnt = 0;
    if (clear_overflow && !(pend_v && m_ovf)) m_ovf = m_ovf;
    pend_v = adc_valid && enable;
    pend_d = (longint'({56'b0, adc_data}) - 64'sd128) * (64'sd1 <<< shift);
    #1;
    compare_model();
  endtask

  task automatic send(input logic [7:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] log_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n && i < 32; i++) m[i] = last_log[i];
    return m;
  endfunction

  initial begin
    aresetn        = 1'b1;
    adc_data       = '0;
    adc_valid      = 1'b0;
    enable         = 1'b0;
    shift          = '0;
    clear_overflow = 1'b0;
    m_tready       = 1'b0;
    model_reset();

    // Reset state
    #2 aresetn = 1'b0;
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_tlast", 64'(m_tlast), 64'h0);
    chk("rst_tdata", m_tdata, 64'h0);
    chk("rst_tstrb", 64'(m_tstrb), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_level", 64'(fifo_level), 64'h0);
    @(posedge clk);
    #1 aresetn = 1'b1;

    // Conversion and scaling
    enable = 1'b1;
    send(8'h80);
    send(8'hFF);
    send(8'h00);
    shift = 4'd4;
    send(8'h00);
    shift = 4'd0;
    idle(2);
    chk("t1_level", 64'(fifo_level), 64'd4);
    chk("t1_s0", m_tdata, 64'h0);
    m_tready = 1'b1;
    tick();
    chk("t1_s1", m_tdata, 64'd127);
    tick();
    chk("t1_s2", m_tdata, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    chk("t1_s3", m_tdata, 64'hFFFF_FFFF_FFFF_F800);
    chk("t1_s3_last", 64'(m_tlast), 64'h1);
    tick();
    m_tready = 1'b0;

    // Fill with 9 samples: one dropped
    for (int i = 0; i < 9; i++) begin
      shift = 4'($urandom_range(0, 15));
      send(8'($urandom_range(0, 255)));
    end
    idle(2);
    chk("t2_level", 64'(fifo_level), 64'd8);
    chk("t2_overflow", 64'(overflow), 64'h1);

    // Clear coincident with a drop, then clear alone
    send(8'($urandom_range(0, 255)));
    clear_overflow = 1'b1;
    tick();
    chk("t6_set_wins", 64'(overflow), 64'h1);
    tick();
    clear_overflow = 1'b0;
    chk("t6_cleared", 64'(overflow), 64'h0);

    // Full FIFO with simultaneous push and pop
    send(8'($urandom_range(0, 255)));
    m_tready = 1'b1;
    tick();
    chk("t4_level", 64'(fifo_level), 64'd8);
    chk("t4_overflow", 64'(overflow), 64'h0);
    idle(10);
    chk("t2_drained", 64'(fifo_level), 64'd0);

    // Framing: 10 samples, tlast on 4th and 8th
    enable = 1'b0;
    tick();
    enable = 1'b1;
    log_n  = 0;
    log_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      shift = 4'($urandom_range(0, 15));
      send(8'($urandom_range(0, 255)));
    end
    idle(4);
    log_en = 1'b0;
    chk("t3_count", 64'(log_n), 64'd10);
    chk("t3_tlast_mask", 64'(log_mask(10)), 64'h088);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      adc_valid      = 1'($urandom_range(0, 1));
      adc_data       = 8'($urandom_range(0, 255));
      enable         = ($urandom_range(0, 7) != 0);
      shift          = 4'($urandom_range(0, 15));
      m_tready       = ($urandom_range(0, 2) != 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      tick();
    end
    adc_valid      = 1'b0;
    clear_overflow = 1'b0;
    enable         = 1'b1;
    m_tready       = 1'b1;
    idle(12);

    // Asynchronous reset mid-burst
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
    idle(1);
    chk("t5_level_pre", 64'(fifo_level), 64'd5);
    #1 aresetn = 1'b0;
    #1;
    chk("t5_tvalid", 64'(m_tvalid), 64'h0);
    chk("t5_level", 64'(fifo_level), 64'h0);
    chk("t5_overflow", 64'(overflow), 64'h0);
    chk("t5_tdata", m_tdata, 64'h0);
    model_reset();
    #1 aresetn = 1'b1;
    m_tready = 1'b1;
    log_n    = 0;
    log_en   = 1'b1;
    for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)));
    idle(3);
    log_en = 1'b0;
    chk("t5_count", 64'(log_n), 64'd4);
    chk("t5_tlast_mask", 64'(log_mask(4)), 64'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
